// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg: types and constants shared by the spibus master and spi_slave.
//   - spi_state_e    : slave frame state (IDLE / ACTIVE)
//   - DEFAULT_DATA_W : default word width in bits
//   - SPI_CPOL/CPHA  : bus mode (mode 0), shared with the master
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int DEFAULT_DATA_W = 8;

  // Mode 0: sclk idles low, data is sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync.sv
// ---------------------------------------------------------------------------
// spi_sync: brings one asynchronous SPI pin into the clk domain.
// A SYNC_STAGES-deep flop chain is followed by one delay flop, so the
// level output and the delayed copy can be compared to find edges.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset (chain loads RESET_VAL)
//   din    in   asynchronous pin
//   level  out  synchronized level
//   rise   out  one-cycle strobe on a synchronized 0->1 transition
//   fall   out  one-cycle strobe on a synchronized 1->0 transition
// ---------------------------------------------------------------------------
module spi_sync
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_r;
  logic                   dly_r;

  // Synchronizer chain plus the delay flop used for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain_r <= {SYNC_STAGES{RESET_VAL}};
      dly_r   <= RESET_VAL;
    end else begin
      chain_r <= {chain_r[SYNC_STAGES-2:0], din};
      dly_r   <= chain_r[SYNC_STAGES-1];
    end
  end

  assign level = chain_r[SYNC_STAGES-1];
  assign rise  = chain_r[SYNC_STAGES-1] & ~dly_r;
  assign fall  = ~chain_r[SYNC_STAGES-1] & dly_r;

endmodule : spi_sync

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave: SPI mode-0 slave, oversampled by the system clock.
// Received words appear on rx_data with a one-cycle rx_valid strobe; the
// word to send is taken from tx_data (strobe tx_taken) at frame start and
// at every word boundary, and shifted out MSB-first on miso.
//
// Ports:
//   clk       in   system clock (sclk must be <= clk/4)
//   reset     in   synchronous active-high reset
//   sclk      in   SPI clock (asynchronous)
//   ss        in   slave select, active low (asynchronous)
//   mosi      in   serial data from master (asynchronous)
//   miso      out  serial data to master
//   tx_data   in   [DATA_W] word to transmit
//   tx_taken  out  pulse when tx_data is captured
//   rx_data   out  [DATA_W] last complete received word
//   rx_valid  out  pulse when rx_data updates
//   frame_err out  pulse when the frame ends mid-word
//                  (only with SPI_SLAVE_FRAME_ERR_EN defined)
//   busy      out  high while the frame is active
//
// Optional feature macro: SPI_SLAVE_FRAME_ERR_EN
// ---------------------------------------------------------------------------
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_taken,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic              frame_err,
`endif
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // Synchronized pins and edge strobes.
  logic sclk_s, sclk_rise_s, sclk_fall_s;
  logic ss_s, ss_rise_s, ss_fall_s;
  logic mosi_s, mosi_rise_s, mosi_fall_s;
  logic sync_unused_s;

  // FSM and datapath registers with their next values.
  spi_state_e        state_r, state_nx;
  logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_nx;
  logic [DATA_W-1:0] tx_sh_r, tx_sh_nx;
  logic [DATA_W-1:0] rx_sh_r, rx_sh_nx;
  logic [DATA_W-1:0] rx_data_r, rx_data_nx;
  logic              rx_valid_r, rx_valid_nx;
  logic              tx_taken_r, tx_taken_nx;
  logic              miso_r, miso_nx;
  logic              busy_r, busy_nx;
  logic [DATA_W-1:0] rx_word_s;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic              frame_err_r, frame_err_nx;
`endif

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .din(sclk),
    .level(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  // ss idles high, so its chain resets to 1 to avoid a false frame start.
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .din(ss),
    .level(ss_s), .rise(ss_rise_s), .fall(ss_fall_s)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .din(mosi),
    .level(mosi_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // Only edges of sclk/ss and the level of mosi drive the logic.
  assign sync_unused_s = ^{sclk_s, ss_s, mosi_rise_s, mosi_fall_s};

  // Word as it stands after shifting in the current mosi sample.
  assign rx_word_s = {rx_sh_r[DATA_W-2:0], mosi_s};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state logic: frames are bounded purely by ss edges.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) begin
          state_nx = ACTIVE;
        end else begin
          state_nx = IDLE;
        end
      end
      ACTIVE: begin
        if (ss_rise_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = ACTIVE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output/datapath next values; ss_rise outranks any sclk edge.
  always_comb begin
    bit_cnt_nx  = bit_cnt_r;
    tx_sh_nx    = tx_sh_r;
    rx_sh_nx    = rx_sh_r;
    rx_data_nx  = rx_data_r;
    rx_valid_nx = 1'b0;
    tx_taken_nx = 1'b0;
    miso_nx     = miso_r;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_nx = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        bit_cnt_nx = '0;
        if (ss_fall_s) begin
          // First bit must be on miso before the first rising sclk.
          miso_nx     = tx_data[DATA_W-1];
          tx_sh_nx    = {tx_data[DATA_W-2:0], 1'b0};
          tx_taken_nx = 1'b1;
        end else begin
          miso_nx = 1'b0;
        end
      end
      ACTIVE: begin
        if (ss_rise_s) begin
          miso_nx    = 1'b0;
          bit_cnt_nx = '0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
          frame_err_nx = (bit_cnt_r != '0);
`endif
        end else if (sclk_rise_s) begin
          rx_sh_nx = rx_word_s;
          if (bit_cnt_r == LAST_BIT) begin
            // Word boundary: deliver it and load the next word unshifted;
            // the following falling sclk puts its MSB on miso.
            rx_data_nx  = rx_word_s;
            rx_valid_nx = 1'b1;
            bit_cnt_nx  = '0;
            tx_sh_nx    = tx_data;
            tx_taken_nx = 1'b1;
          end else begin
            bit_cnt_nx = bit_cnt_r + CNT_W'(1);
          end
        end else if (sclk_fall_s) begin
          miso_nx  = tx_sh_r[DATA_W-1];
          tx_sh_nx = {tx_sh_r[DATA_W-2:0], 1'b0};
        end else begin
          miso_nx = miso_r;
        end
      end
      default: begin
        bit_cnt_nx = '0;
        miso_nx    = 1'b0;
      end
    endcase
    busy_nx = (state_nx == ACTIVE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_r  <= '0;
      tx_sh_r    <= '0;
      rx_sh_r    <= '0;
      rx_data_r  <= '0;
      rx_valid_r <= 1'b0;
      tx_taken_r <= 1'b0;
      miso_r     <= 1'b0;
      busy_r     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_r <= 1'b0;
`endif
    end else begin
      bit_cnt_r  <= bit_cnt_nx;
      tx_sh_r    <= tx_sh_nx;
      rx_sh_r    <= rx_sh_nx;
      rx_data_r  <= rx_data_nx;
      rx_valid_r <= rx_valid_nx;
      tx_taken_r <= tx_taken_nx;
      miso_r     <= miso_nx;
      busy_r     <= busy_nx;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err_r <= frame_err_nx;
`endif
    end
  end

  assign miso     = miso_r;
  assign tx_taken = tx_taken_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  assign frame_err = frame_err_r;
`endif

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave: directed bench for spi_slave (8-bit and 16-bit instances
// sharing the same SPI pins). sclk runs at clk/8; mosi changes while sclk
// is low and miso is captured at each rising sclk.
// ---------------------------------------------------------------------------
module tb_spi_slave;

  logic clk = 1'b0;
  logic reset;
  logic sclk, ss, mosi;

  logic        miso8, tx_taken8, rx_valid8, busy8;
  logic [7:0]  tx_data8, rx_data8;
  logic        miso16, tx_taken16, rx_valid16, busy16;
  logic [15:0] tx_data16, rx_data16;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic        frame_err8, frame_err16;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Event monitors (written only by the always block below).
  int         rx8_cnt = 0, tx8_cnt = 0, rx16_cnt = 0, fe8_cnt = 0;
  logic [7:0]  rx_hist8 [0:31];
  logic [15:0] rx_hist16 [0:31];

  // miso bits captured by the master task at rising sclk.
  logic [15:0] cap8, cap16;

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso8), .tx_data(tx_data8), .tx_taken(tx_taken8),
    .rx_data(rx_data8), .rx_valid(rx_valid8),
`ifdef SPI_SLAVE_FRAME_ERR_EN
    .frame_err(frame_err8),
`endif
    .busy(busy8)
  );

  spi_slave #(.DATA_W(16), .SYNC_STAGES(2)) dut16 (
    .clk(clk), .reset(reset), .sclk(sclk), .ss(ss), .mosi(mosi),
    .miso(miso16), .tx_data(tx_data16), .tx_taken(tx_taken16),
    .rx_data(rx_data16), .rx_valid(rx_valid16),
`ifdef SPI_SLAVE_FRAME_ERR_EN
    .frame_err(frame_err16),
`endif
    .busy(busy16)
  );

  // Count strobes and log delivered words, sampled away from posedge.
  always @(negedge clk) begin
    if (rx_valid8) begin
      rx_hist8[rx8_cnt[4:0]] <= rx_data8;
      rx8_cnt <= rx8_cnt + 1;
    end
    if (tx_taken8) tx8_cnt <= tx8_cnt + 1;
    if (rx_valid16) begin
      rx_hist16[rx16_cnt[4:0]] <= rx_data16;
      rx16_cnt <= rx16_cnt + 1;
    end
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (frame_err8) fe8_cnt <= fe8_cnt + 1;
`endif
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master side of mode 0: drive mosi while sclk low, sample miso on rise.
  task automatic send_bits(input logic [15:0] data, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      wait_clk(4);
      sclk = 1'b1;
      cap8  = {cap8[14:0], miso8};
      cap16 = {cap16[14:0], miso16};
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  int rxb, txb, rx16b, feb;

  initial begin
    reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_data8 = 8'h00; tx_data16 = 16'h1234;
    cap8 = 16'h0000; cap16 = 16'h0000;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);

    // Reset state
    check_eq("rst_miso", {31'd0, miso8}, 32'd0);
    check_eq("rst_busy", {31'd0, busy8}, 32'd0);
    check_eq("rst_rx_data", {24'd0, rx_data8}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid8}, 32'd0);
    check_eq("rst_tx_taken", {31'd0, tx_taken8}, 32'd0);

    // Idle: sclk toggles with ss high are ignored
    for (int k = 0; k < 4; k++) begin
      mosi = 1'b1; sclk = 1'b1; wait_clk(4); sclk = 1'b0; wait_clk(4);
    end
    wait_clk(4);
    check_eq("idle_rx_cnt", rx8_cnt, 32'd0);
    check_eq("idle_tx_cnt", tx8_cnt, 32'd0);
    check_eq("idle_miso", {31'd0, miso8}, 32'd0);
    check_eq("idle_busy", {31'd0, busy8}, 32'd0);

    // Single frame: A5 out, 05 in
    tx_data8 = 8'hA5;
    rxb = rx8_cnt; txb = tx8_cnt;
    ss = 1'b0;
    wait_clk(8);
    check_eq("single_busy", {31'd0, busy8}, 32'd1);
    check_eq("single_tx_start", tx8_cnt - txb, 32'd1);
    cap8 = 16'h0000;
    send_bits(16'h0005, 8);
    wait_clk(8);
    check_eq("single_rx_cnt", rx8_cnt - rxb, 32'd1);
    check_eq("single_rx_data", {24'd0, rx_hist8[rxb[4:0]]}, 32'h05);
    check_eq("single_miso", {24'd0, cap8[7:0]}, 32'hA5);
    check_eq("single_tx_cnt", tx8_cnt - txb, 32'd2);
    ss = 1'b1;
    wait_clk(8);
    check_eq("single_end_busy", {31'd0, busy8}, 32'd0);
    check_eq("single_end_miso", {31'd0, miso8}, 32'd0);

    // Back-to-back words within one frame
    tx_data8 = 8'h81;
    rxb = rx8_cnt; txb = tx8_cnt;
    ss = 1'b0;
    wait_clk(8);
    tx_data8 = 8'h7E;
    cap8 = 16'h0000;
    send_bits(16'h003C, 8);
    check_eq("b2b_miso0", {24'd0, cap8[7:0]}, 32'h81);
    cap8 = 16'h0000;
    send_bits(16'h00C3, 8);
    check_eq("b2b_miso1", {24'd0, cap8[7:0]}, 32'h7E);
    wait_clk(8);
    check_eq("b2b_rx_cnt", rx8_cnt - rxb, 32'd2);
    check_eq("b2b_rx0", {24'd0, rx_hist8[rxb[4:0]]}, 32'h3C);
    check_eq("b2b_rx1", {24'd0, rx_hist8[5'(rxb + 1)]}, 32'hC3);
    check_eq("b2b_tx_cnt", tx8_cnt - txb, 32'd3);
    ss = 1'b1;
    wait_clk(8);

    // Abort after 5 bits
    tx_data8 = 8'hFF;
    rxb = rx8_cnt; feb = fe8_cnt;
    ss = 1'b0;
    wait_clk(8);
    send_bits(16'h0015, 5);
    wait_clk(4);
    ss = 1'b1;
    wait_clk(3);
    check_eq("abort_busy", {31'd0, busy8}, 32'd0);
    check_eq("abort_miso", {31'd0, miso8}, 32'd0);
    wait_clk(8);
    check_eq("abort_rx_cnt", rx8_cnt - rxb, 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check_eq("abort_frame_err", fe8_cnt - feb, 32'd1);
`endif
    rxb = rx8_cnt;
    ss = 1'b0;
    wait_clk(8);
    send_bits(16'h00FF, 8);
    wait_clk(8);
    ss = 1'b1;
    wait_clk(8);
    check_eq("after_abort_rx_cnt", rx8_cnt - rxb, 32'd1);
    check_eq("after_abort_rx", {24'd0, rx_hist8[rxb[4:0]]}, 32'hFF);

    // Reset in the middle of a frame
    ss = 1'b0;
    wait_clk(8);
    send_bits(16'h0005, 3);
    reset = 1'b1;
    wait_clk(1);
    check_eq("mrst_miso", {31'd0, miso8}, 32'd0);
    check_eq("mrst_busy", {31'd0, busy8}, 32'd0);
    check_eq("mrst_rx_data", {24'd0, rx_data8}, 32'd0);
    check_eq("mrst_rx_valid", {31'd0, rx_valid8}, 32'd0);
    check_eq("mrst_tx_taken", {31'd0, tx_taken8}, 32'd0);
    reset = 1'b0;
    ss = 1'b1;
    wait_clk(8);
    rxb = rx8_cnt;
    ss = 1'b0;
    wait_clk(8);
    send_bits(16'h005A, 8);
    wait_clk(8);
    ss = 1'b1;
    wait_clk(8);
    check_eq("mrst_new_rx_cnt", rx8_cnt - rxb, 32'd1);
    check_eq("mrst_new_rx", {24'd0, rx_hist8[rxb[4:0]]}, 32'h5A);

    // 16-bit instance: BEEF in, 1234 out
    rx16b = rx16_cnt;
    ss = 1'b0;
    wait_clk(8);
    cap16 = 16'h0000;
    send_bits(16'hBEEF, 16);
    wait_clk(8);
    check_eq("w16_rx_cnt", rx16_cnt - rx16b, 32'd1);
    check_eq("w16_rx", {16'd0, rx_hist16[rx16b[4:0]]}, 32'hBEEF);
    check_eq("w16_miso", {16'd0, cap16}, 32'h1234);
    ss = 1'b1;
    wait_clk(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_spi_slave
